// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel edge stream: kernel taps, magnitude metric and direction codes,
// plus the magnitude/threshold width helper.
package sobel_pkg;

  localparam int unsigned NUM_TAPS = 9;

  typedef logic signed [2:0] coef_t;

  // Tap k = row*3+col, row 0 at the top, col 0 on the left.
  localparam coef_t GX_COEF [NUM_TAPS] = '{
    -3'sd1, 3'sd0, 3'sd1,
    -3'sd2, 3'sd0, 3'sd2,
    -3'sd1, 3'sd0, 3'sd1
  };

  localparam coef_t GY_COEF [NUM_TAPS] = '{
    -3'sd1, -3'sd2, -3'sd1,
     3'sd0,  3'sd0,  3'sd0,
     3'sd1,  3'sd2,  3'sd1
  };

  localparam int unsigned MAG_L2 = 0;
  localparam int unsigned MAG_L1 = 1;

  typedef enum logic [1:0] {
    DIR_H    = 2'd0,
    DIR_D45  = 2'd1,
    DIR_V    = 2'd2,
    DIR_D135 = 2'd3
  } dir_e;

  function automatic int unsigned mag_width(input int unsigned pw);
    return 2 * pw + 5;
  endfunction

endpackage

// File: rtl/sobel_grad.sv
// Combinational Sobel gradients gx/gy from one packed 3x3 window of unsigned pixels.
module sobel_grad
  import sobel_pkg::*;
#(
  parameter int unsigned PW = 8
) (
  input  logic [9*PW-1:0]      window_i,
  output logic signed [PW+2:0] gx_o,
  output logic signed [PW+2:0] gy_o
);

  localparam int unsigned GW = PW + 3;

  logic signed [GW-1:0] pix;
  logic signed [GW-1:0] gx_acc;
  logic signed [GW-1:0] gy_acc;

  // PW+3 signed bits hold +-4*(2^PW-1), so the truncating sums never overflow.
  always_comb begin
    pix    = '0;
    gx_acc = '0;
    gy_acc = '0;
    for (int k = 0; k < int'(NUM_TAPS); k++) begin
      pix    = $signed({3'b000, window_i[k*PW +: PW]});
      gx_acc = gx_acc + $signed({{PW{GX_COEF[k][2]}}, GX_COEF[k]}) * pix;
      gy_acc = gy_acc + $signed({{PW{GY_COEF[k][2]}}, GY_COEF[k]}) * pix;
    end
  end

  assign gx_o = gx_acc;
  assign gy_o = gy_acc;

endmodule

// File: rtl/sobel_edge_stream.sv
// Three-stage streaming Sobel edge detector with valid/ready flow control and an edge counter.
// Defining SOBEL_EDGE_DIR_EN adds the quantised gradient direction output o_edge_dir.
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter  int unsigned PW       = 8,
  parameter  int unsigned MAG_MODE = MAG_L2,
  parameter  int unsigned CNT_W    = 16,
  localparam int unsigned MAG_W    = mag_width(PW)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [9*PW-1:0]   i_pixel_data,
  input  logic              i_pixel_data_valid,
  output logic              o_ready,
  input  logic [MAG_W-1:0]  i_threshold,
  input  logic              i_clear,
  output logic [PW-1:0]     o_convolved_data,
  output logic              o_convolved_data_valid,
  input  logic              i_ready,
  output logic [CNT_W-1:0]  o_edge_count
`ifdef SOBEL_EDGE_DIR_EN
  ,
  output logic [1:0]        o_edge_dir
`endif
);

  localparam int unsigned GW = PW + 3;

  logic                 v1_q, v2_q, v3_q;
  logic                 ld1, ld2, ld3, acc;
  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
  logic [GW-1:0]        ax, ay;
  logic [MAG_W-1:0]     ax_w, ay_w, mag_d, mag_q;
  logic [PW-1:0]        out_q;
  logic                 is_edge_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  // Each stage loads when empty or when its content leaves this cycle.
  assign ld3     = !v3_q || i_ready;
  assign ld2     = !v2_q || ld3;
  assign ld1     = !v1_q || ld2;
  assign o_ready = ld1;
  assign acc     = i_pixel_data_valid && ld1;

  sobel_grad #(
    .PW (PW)
  ) u_grad (
    .window_i (i_pixel_data),
    .gx_o     (gx_c),
    .gy_o     (gy_c)
  );

  assign ax   = gx_q[GW-1] ? $unsigned(-gx_q) : $unsigned(gx_q);
  assign ay   = gy_q[GW-1] ? $unsigned(-gy_q) : $unsigned(gy_q);
  assign ax_w = {{(MAG_W-GW){1'b0}}, ax};
  assign ay_w = {{(MAG_W-GW){1'b0}}, ay};

  always_comb begin
    if (MAG_MODE == MAG_L1) begin
      mag_d = ax_w + ay_w;
    end else begin
      mag_d = ax_w * ax_w + ay_w * ay_w;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (v3_q && i_ready && is_edge_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

`ifdef SOBEL_EDGE_DIR_EN
  dir_e       dir_d, dir_q;
  logic [1:0] dir3_q;

  always_comb begin
    if ({ay, 1'b0} <= {1'b0, ax}) begin
      dir_d = DIR_H;
    end else if ({ax, 1'b0} <= {1'b0, ay}) begin
      dir_d = DIR_V;
    end else if (gx_q[GW-1] == gy_q[GW-1]) begin
      dir_d = DIR_D45;
    end else begin
      dir_d = DIR_D135;
    end
  end

  always_ff @(posedge i_clk) begin
    if (ld2 && v1_q) begin
      dir_q <= dir_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      dir3_q <= 2'd0;
    end else if (ld3 && v2_q) begin
      dir3_q <= dir_q;
    end
  end

  assign o_edge_dir = dir3_q;
`endif

  // Datapath registers without reset; only the valids and visible outputs are cleared.
  always_ff @(posedge i_clk) begin
    if (acc) begin
      gx_q <= gx_c;
      gy_q <= gy_c;
    end
    if (ld2 && v1_q) begin
      mag_q <= mag_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      out_q     <= '0;
      is_edge_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (ld1) v1_q <= acc;
      if (ld2) v2_q <= v1_q;
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          is_edge_q <= (mag_q > i_threshold);
          out_q     <= (mag_q > i_threshold) ? {PW{1'b1}} : {PW{1'b0}};
        end
      end
      cnt_q <= cnt_d;
    end
  end

  assign o_convolved_data       = out_q;
  assign o_convolved_data_valid = v3_q;
  assign o_edge_count           = cnt_q;

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench: DUT A (L2, 16-bit counter) and DUT B (L1, 4-bit counter) share one stream.
module tb_sobel_edge_stream;

  localparam int unsigned PW = 8;
  localparam int unsigned MW = 2 * PW + 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, valid, rdy, clr;
  logic [9*PW-1:0] pdata;
  logic [MW-1:0]   thr_a, thr_b;
  logic            ordy_a, ordy_b, ovld_a, ovld_b;
  logic [PW-1:0]   od_a, od_b;
  logic [15:0]     cnt_a;
  logic [3:0]      cnt_b;
  logic [1:0]      dir_a, dir_b;

  sobel_edge_stream #(.PW(PW), .MAG_MODE(0), .CNT_W(16)) u_dut_a (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_pixel_data           (pdata),
    .i_pixel_data_valid     (valid),
    .o_ready                (ordy_a),
    .i_threshold            (thr_a),
    .i_clear                (clr),
    .o_convolved_data       (od_a),
    .o_convolved_data_valid (ovld_a),
    .i_ready                (rdy),
    .o_edge_count           (cnt_a)
`ifdef SOBEL_EDGE_DIR_EN
    ,
    .o_edge_dir             (dir_a)
`endif
  );

  sobel_edge_stream #(.PW(PW), .MAG_MODE(1), .CNT_W(4)) u_dut_b (
    .i_clk                  (clk),
    .i_rst_n                (rst_n),
    .i_pixel_data           (pdata),
    .i_pixel_data_valid     (valid),
    .o_ready                (ordy_b),
    .i_threshold            (thr_b),
    .i_clear                (clr),
    .o_convolved_data       (od_b),
    .o_convolved_data_valid (ovld_b),
    .i_ready                (rdy),
    .o_edge_count           (cnt_b)
`ifdef SOBEL_EDGE_DIR_EN
    ,
    .o_edge_dir             (dir_b)
`endif
  );

`ifndef SOBEL_EDGE_DIR_EN
  assign dir_a = 2'd0;
  assign dir_b = 2'd0;
`endif

  typedef struct {
    logic [PW-1:0] data;
    logic [1:0]    dir;
    int            cyc;
    bit            lat;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_cnt [2] = '{0, 0};
  int cnt_max [2] = '{65535, 15};
  bit held_v [2] = '{1'b0, 1'b0};
  logic [PW-1:0] held_d [2];

  // Hand-computed per window: gx^2+gy^2, |gx|+|gy|, direction code.
  int unsigned vec [8][9];
  int unsigned l2  [8] = '{0, 1040400, 1600, 5000, 5000, 1170450, 130050, 3600};
  int unsigned l1  [8] = '{0, 1020, 40, 100, 100, 1530, 510, 60};
  logic [1:0]  dr  [8] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd3, 2'd1, 2'd1, 2'd2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic mon(input int d, input logic vld, input logic [PW-1:0] dat,
                     input logic [1:0] dir);
    exp_t e;
    bit   edge_dlv;
    int   qs;
    edge_dlv = 1'b0;
    if (vld && held_v[d]) chk(d == 0 ? "hold_a" : "hold_b", dat, held_d[d]);
    if (vld && rdy) begin
      qs = (d == 0) ? q_a.size() : q_b.size();
      if (qs == 0) begin
        chk(d == 0 ? "unexpected_a" : "unexpected_b", 1, 0);
      end else begin
        e = (d == 0) ? q_a.pop_front() : q_b.pop_front();
        chk(d == 0 ? "data_a" : "data_b", dat, e.data);
        if (e.lat) chk(d == 0 ? "latency_a" : "latency_b", cyc - e.cyc, 3);
`ifdef SOBEL_EDGE_DIR_EN
        chk(d == 0 ? "dir_a" : "dir_b", dir, e.dir);
`endif
        edge_dlv = (e.data != '0);
      end
    end
    held_v[d] = vld && !rdy;
    held_d[d] = dat;
    if (clr) exp_cnt[d] = 0;
    else if (edge_dlv && exp_cnt[d] < cnt_max[d]) exp_cnt[d]++;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      q_a.delete();
      q_b.delete();
      held_v     = '{1'b0, 1'b0};
      exp_cnt    = '{0, 0};
    end else begin
      mon(0, ovld_a, od_a, dir_a);
      mon(1, ovld_b, od_b, dir_b);
    end
  end

  task automatic send(input int v, input bit lat, output int tries);
    exp_t ea, eb;
    bit   done;
    for (int k = 0; k < 9; k++) pdata[k*PW +: PW] = PW'(vec[v][k]);
    valid = 1'b1;
    done  = 1'b0;
    tries = 0;
    while (!done && tries < 64) begin
      @(negedge clk);
      tries++;
      if (ordy_a) begin
        done    = 1'b1;
        ea.data = (l2[v] > thr_a) ? {PW{1'b1}} : '0;
        eb.data = (l1[v] > thr_b) ? {PW{1'b1}} : '0;
        ea.dir  = dr[v];
        eb.dir  = dr[v];
        ea.cyc  = cyc;
        eb.cyc  = cyc;
        ea.lat  = lat;
        eb.lat  = lat;
        q_a.push_back(ea);
        q_b.push_back(eb);
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    int w;
    vec[0] = '{100, 100, 100, 100, 100, 100, 100, 100, 100};
    vec[1] = '{0, 128, 255, 0, 128, 255, 0, 128, 255};
    vec[2] = '{0, 0, 0, 0, 0, 0, 10, 10, 10};
    vec[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 50};
    vec[4] = '{0, 0, 0, 0, 0, 0, 50, 0, 0};
    vec[5] = '{0, 0, 255, 0, 0, 255, 255, 255, 255};
    vec[6] = '{255, 0, 0, 0, 0, 0, 0, 0, 0};
    vec[7] = '{0, 30, 0, 0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; valid = 1'b0; rdy = 1'b1; clr = 1'b0; pdata = '0;
    thr_a = MW'(4000); thr_b = MW'(1020);
    idle(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_a", ordy_a, 1);
    chk("rst_valid_a", ovld_a, 0);
    chk("rst_data_a", od_a, 0);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_valid_b", ovld_b, 0);
    chk("rst_cnt_b", cnt_b, 0);
`ifdef SOBEL_EDGE_DIR_EN
    chk("rst_dir_a", dir_a, 0);
`endif
    @(posedge clk);
    #1;

    // Back-to-back stream: every window must be taken on its first cycle.
    for (int v = 0; v < 8; v++) begin
      send(v, 1'b1, tries);
      chk("throughput", tries, 1);
    end
    idle(6);
    chk("cnt_a_phase1", cnt_a, 5);
    chk("cnt_b_phase1", cnt_b, 1);

    thr_b = MW'(1019);
    send(1, 1'b1, tries);
    idle(6);
    chk("cnt_b_l1_1019", cnt_b, 2);

    // Backpressure: three accepts fill the pipe, then o_ready must stay low.
    rdy = 1'b0;
    for (int v = 1; v <= 3; v++) send(v, 1'b0, tries);
    for (int k = 0; k < 9; k++) pdata[k*PW +: PW] = PW'(vec[4][k]);
    valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("ready_low_full", ordy_a, 0);
      chk("valid_held", ovld_a, 1);
      @(posedge clk);
      #1;
    end
    rdy = 1'b1;
    send(4, 1'b0, tries);
    chk("resume_same_cycle", tries, 1);
    send(5, 1'b0, tries);
    send(6, 1'b0, tries);
    idle(6);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    chk("cnt_a_model", cnt_a, exp_cnt[0]);

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++) send(1, 1'b1, tries);
    idle(6);
    chk("cnt_b_sat", cnt_b, 15);
    chk("cnt_a_model2", cnt_a, exp_cnt[0]);

    // Clear coinciding with an edge delivery.
    rdy = 1'b0;
    send(1, 1'b0, tries);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!ovld_a && w < 10);
    chk("clear_setup_valid", ovld_a, 1);
    @(posedge clk);
    #1;
    rdy = 1'b1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(negedge clk);
    chk("clear_cnt_a", cnt_a, 0);
    chk("clear_cnt_b", cnt_b, 0);
    chk("clear_valid", ovld_a, 0);
    @(posedge clk);
    #1;

    // Reset with two windows in flight.
    send(1, 1'b0, tries);
    send(3, 1'b0, tries);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_valid_a", ovld_a, 0);
      chk("post_rst_valid_b", ovld_b, 0);
      chk("post_rst_ready", ordy_a, 1);
      @(posedge clk);
      #1;
    end
    chk("post_rst_cnt_a", cnt_a, 0);
    chk("post_rst_cnt_b", cnt_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
